// File: rtl/fpnew_pkg.sv
// Shared FPnew types and helpers: format widths, lane counts, status flags,
// rounding modes and operation codes.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL,
        DIVSQRT, SQRT,
        SGNJ, MINMAX, CMP, CLASSIFY,
        F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            FP16ALT: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int unsigned num_lanes(int unsigned width, fp_format_e fmt, logic vec);
        return vec ? width / fp_width(fmt) : 1;
    endfunction

endpackage

// File: rtl/fpnew_lane_sequencer.sv
// Time-multiplexes a packed vector operation through a single external lane
// unit, issuing one element per handshake and reassembling the packed result.
module fpnew_lane_sequencer
    import fpnew_pkg::*;
#(
    parameter fp_format_e   FpFormat      = fp_format_e'(0),
    parameter int unsigned  Width         = 32,
    parameter logic         EnableVectors = 1'b1,
    parameter int unsigned  NumOperands   = 3,
    parameter type          TagType       = logic,
    localparam int unsigned FP_WIDTH      = fp_width(FpFormat),
    localparam int unsigned NUM_LANES     = num_lanes(Width, FpFormat, EnableVectors)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumOperands-1:0][Width-1:0]      operands_i,
    input  logic [NumOperands-1:0]                 is_boxed_i,
    input  roundmode_e                             rnd_mode_i,
    input  operation_e                             op_i,
    input  logic                                   op_mod_i,
    input  logic                                   vectorial_op_i,
    input  TagType                                 tag_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic                                   flush_i,
    output logic [Width-1:0]                       result_o,
    output status_t                                status_o,
    output logic                                   extension_bit_o,
    output TagType                                 tag_o,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic                                   busy_o,
    output logic [NumOperands-1:0][FP_WIDTH-1:0]   lane_operands_o,
    output logic [NumOperands-1:0]                 lane_is_boxed_o,
    output roundmode_e                             lane_rnd_mode_o,
    output operation_e                             lane_op_o,
    output logic                                   lane_op_mod_o,
    output TagType                                 lane_tag_o,
    output logic                                   lane_in_valid_o,
    input  logic                                   lane_in_ready_i,
    input  logic [FP_WIDTH-1:0]                    lane_result_i,
    input  status_t                                lane_status_i,
    input  logic                                   lane_ext_bit_i,
    input  logic                                   lane_out_valid_i,
    output logic                                   lane_out_ready_o,
    output logic                                   lane_flush_o
);

    localparam int unsigned CNT_W = $clog2(NUM_LANES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef logic [CNT_W-1:0] cnt_t;

    state_e                               r_state;
    logic [NumOperands-1:0][Width-1:0]    r_operands;
    logic [NumOperands-1:0]               r_isBoxed;
    roundmode_e                           r_rndMode;
    operation_e                           r_op;
    logic                                 r_opMod;
    TagType                               r_tag;
    cnt_t                                 r_numElem;
    cnt_t                                 r_issueCnt;
    cnt_t                                 r_collectCnt;
    logic [NUM_LANES-1:0][FP_WIDTH-1:0]   r_slots;
    status_t                              r_status;
    logic                                 r_extBit;

    logic                                 w_laneInValid;
    logic                                 w_issueFire;
    logic                                 w_collectFire;
    logic [NumOperands-1:0][FP_WIDTH-1:0] w_laneOperands;
    logic [Width-1:0]                     w_result;

    assign w_laneInValid = (r_state == RUN) && (r_issueCnt < r_numElem);
    assign w_issueFire   = w_laneInValid && lane_in_ready_i;
    assign w_collectFire = (r_state == RUN) && lane_out_valid_i && (r_collectCnt < r_numElem);

    // Select the current element slice of every operand; a mux avoids an
    // out-of-range part-select once issue has run past the last element.
    always_comb begin
        w_laneOperands = '0;
        for (int k = 0; k < NumOperands; k++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (r_issueCnt == cnt_t'(l)) begin
                    w_laneOperands[k] = r_operands[k][l*FP_WIDTH +: FP_WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_result = {Width{r_extBit}};
        for (int l = 0; l < NUM_LANES; l++) begin
            if (cnt_t'(l) < r_numElem) begin
                w_result[l*FP_WIDTH +: FP_WIDTH] = r_slots[l];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_operands   <= '0;
            r_isBoxed    <= '0;
            r_rndMode    <= RNE;
            r_op         <= FMADD;
            r_opMod      <= 1'b0;
            r_tag        <= '0;
            r_numElem    <= '0;
            r_issueCnt   <= '0;
            r_collectCnt <= '0;
            r_slots      <= '0;
            r_status     <= '0;
            r_extBit     <= 1'b0;
        end else if (flush_i) begin
            r_state      <= IDLE;
            r_issueCnt   <= '0;
            r_collectCnt <= '0;
            r_status     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_operands   <= operands_i;
                        r_isBoxed    <= is_boxed_i;
                        r_rndMode    <= rnd_mode_i;
                        r_op         <= op_i;
                        r_opMod      <= op_mod_i;
                        r_tag        <= tag_i;
                        r_numElem    <= (vectorial_op_i && EnableVectors) ? cnt_t'(NUM_LANES) : cnt_t'(1);
                        r_issueCnt   <= '0;
                        r_collectCnt <= '0;
                        r_status     <= '0;
                        r_extBit     <= 1'b0;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    if (w_issueFire) begin
                        r_issueCnt <= r_issueCnt + cnt_t'(1);
                    end
                    if (w_collectFire) begin
                        for (int l = 0; l < NUM_LANES; l++) begin
                            if (r_collectCnt == cnt_t'(l)) begin
                                r_slots[l] <= lane_result_i;
                            end
                        end
                        if (r_collectCnt == '0) begin
                            r_extBit <= lane_ext_bit_i;
                        end
                        r_status     <= status_t'(r_status | lane_status_i);
                        r_collectCnt <= r_collectCnt + cnt_t'(1);
                    end
                    // The final element is registered first, so DONE follows one cycle later.
                    if (r_collectCnt == r_numElem) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready_o       = (r_state == IDLE);
    assign out_valid_o      = (r_state == DONE);
    assign busy_o           = (r_state != IDLE);
    assign result_o         = w_result;
    assign status_o         = r_status;
    assign extension_bit_o  = r_extBit;
    assign tag_o            = r_tag;

    assign lane_operands_o  = w_laneOperands;
    assign lane_is_boxed_o  = r_isBoxed;
    assign lane_rnd_mode_o  = r_rndMode;
    assign lane_op_o        = r_op;
    assign lane_op_mod_o    = r_opMod;
    assign lane_tag_o       = r_tag;
    assign lane_in_valid_o  = w_laneInValid;
    assign lane_out_ready_o = 1'b1;
    assign lane_flush_o     = flush_i;

endmodule

// File: tb/tb_fpnew_lane_sequencer.sv
// Directed bench for fpnew_lane_sequencer (FP16 elements in a 32-bit slice);
// the lane answers by element index taken from bit 0 of operand 0's slice.
module tb_fpnew_lane_sequencer;
    import fpnew_pkg::*;

    logic              clk = 1'b0;
    logic              rstN;
    logic [2:0][31:0]  operands;
    logic [2:0]        isBoxed;
    roundmode_e        rndMode;
    operation_e        op;
    logic              opMod;
    logic              vectorialOp;
    logic [3:0]        tag;
    logic              inValid;
    logic              inReady;
    logic              flush;
    logic [31:0]       result;
    status_t           status;
    logic              extBit;
    logic [3:0]        tagOut;
    logic              outValid;
    logic              outReady;
    logic              busy;
    logic [2:0][15:0]  laneOperands;
    logic [2:0]        laneIsBoxed;
    roundmode_e        laneRndMode;
    operation_e        laneOp;
    logic              laneOpMod;
    logic [3:0]        laneTag;
    logic              laneInValid;
    logic              laneInReady;
    logic [15:0]       laneResult;
    status_t           laneStatus;
    logic              laneExtBit;
    logic              laneOutValid;
    logic              laneOutReady;
    logic              laneFlush;

    logic              laneAuto;
    logic              laneReady;
    logic              laneManValid;
    logic [15:0]       laneManData;
    logic [15:0]       resp0Data;
    logic [15:0]       resp1Data;
    logic [4:0]        resp0Status;
    logic [4:0]        resp1Status;
    logic              resp0Ext;
    logic              resp1Ext;
    logic              laneSel;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    assign laneInReady  = laneReady;
    assign laneSel      = laneOperands[0][0];
    assign laneOutValid = laneAuto ? (laneInValid & laneReady) : laneManValid;
    assign laneResult   = !laneAuto ? laneManData : (laneSel ? resp1Data : resp0Data);
    assign laneStatus   = status_t'(!laneAuto ? 5'b0 : (laneSel ? resp1Status : resp0Status));
    assign laneExtBit   = laneAuto & (laneSel ? resp1Ext : resp0Ext);

    fpnew_lane_sequencer #(
        .FpFormat      (FP16),
        .Width         (32),
        .EnableVectors (1'b1),
        .NumOperands   (3),
        .TagType       (logic [3:0])
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rstN),
        .operands_i       (operands),
        .is_boxed_i       (isBoxed),
        .rnd_mode_i       (rndMode),
        .op_i             (op),
        .op_mod_i         (opMod),
        .vectorial_op_i   (vectorialOp),
        .tag_i            (tag),
        .in_valid_i       (inValid),
        .in_ready_o       (inReady),
        .flush_i          (flush),
        .result_o         (result),
        .status_o         (status),
        .extension_bit_o  (extBit),
        .tag_o            (tagOut),
        .out_valid_o      (outValid),
        .out_ready_i      (outReady),
        .busy_o           (busy),
        .lane_operands_o  (laneOperands),
        .lane_is_boxed_o  (laneIsBoxed),
        .lane_rnd_mode_o  (laneRndMode),
        .lane_op_o        (laneOp),
        .lane_op_mod_o    (laneOpMod),
        .lane_tag_o       (laneTag),
        .lane_in_valid_o  (laneInValid),
        .lane_in_ready_i  (laneInReady),
        .lane_result_i    (laneResult),
        .lane_status_i    (laneStatus),
        .lane_ext_bit_i   (laneExtBit),
        .lane_out_valid_i (laneOutValid),
        .lane_out_ready_o (laneOutReady),
        .lane_flush_o     (laneFlush)
    );

    // Returns at the negedge just after the accepting posedge.
    task automatic applyStimulus(input logic vec, input logic [3:0] t);
        @(negedge clk);
        operands    = {32'h3333_4444, 32'h1111_2222, 32'h0001_0000};
        isBoxed     = 3'b101;
        rndMode     = RTZ;
        op          = MUL;
        opMod       = 1'b1;
        vectorialOp = vec;
        tag         = t;
        inValid     = 1'b1;
        @(negedge clk);
        inValid     = 1'b0;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (!outValid && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic completeOp();
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        testsRun++;
        if (inReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", inReady); end
        testsRun++;
        if (outValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", outValid); end
        testsRun++;
        if (laneInValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_lane_in_valid: got %b, expected 0", laneInValid); end
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        testsRun++;
        if (result !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_result: got %h, expected 00000000", result); end
        testsRun++;
        if (status !== 5'b0) begin testsFailed++; $display("[TB] FAIL reset_status: got %b, expected 00000", status); end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_scalar();
        int cyc;
        laneAuto = 1'b1; laneReady = 1'b1;
        resp0Data = 16'h3C00; resp0Status = 5'b0; resp0Ext = 1'b1;
        applyStimulus(1'b0, 4'hA);
        testsRun++;
        if ({busy, inReady, laneInValid} !== 3'b101) begin testsFailed++; $display("[TB] FAIL scalar_run_flags: got %b, expected 101", {busy, inReady, laneInValid}); end
        testsRun++;
        if ({laneOperands[1], laneOperands[2]} !== {16'h2222, 16'h4444}) begin testsFailed++; $display("[TB] FAIL scalar_operands: got %h, expected 22224444", {laneOperands[1], laneOperands[2]}); end
        testsRun++;
        if ({laneIsBoxed, laneRndMode, laneOp, laneOpMod, laneTag} !== {3'b101, RTZ, MUL, 1'b1, 4'hA}) begin testsFailed++; $display("[TB] FAIL scalar_lane_controls: got %h, expected %h", {laneIsBoxed, laneRndMode, laneOp, laneOpMod, laneTag}, {3'b101, RTZ, MUL, 1'b1, 4'hA}); end
        waitValid(cyc);
        testsRun++;
        if (cyc !== 2) begin testsFailed++; $display("[TB] FAIL scalar_latency: got %0d, expected 2", cyc); end
        testsRun++;
        if (result !== 32'hFFFF_3C00) begin testsFailed++; $display("[TB] FAIL scalar_result: got %h, expected ffff3c00", result); end
        testsRun++;
        if ({status, extBit, tagOut} !== {5'b0, 1'b1, 4'hA}) begin testsFailed++; $display("[TB] FAIL scalar_status_ext_tag: got %h, expected %h", {status, extBit, tagOut}, {5'b0, 1'b1, 4'hA}); end
        completeOp();
        testsRun++;
        if ({inReady, busy, outValid} !== 3'b100) begin testsFailed++; $display("[TB] FAIL scalar_back_to_idle: got %b, expected 100", {inReady, busy, outValid}); end
    endtask

    // Leaves the operation sitting in DONE for test_backpressure.
    task automatic test_vector();
        int cyc;
        laneAuto = 1'b1; laneReady = 1'b1;
        resp0Data = 16'h3C00; resp0Status = 5'b00001; resp0Ext = 1'b0;
        resp1Data = 16'h4000; resp1Status = 5'b00100; resp1Ext = 1'b1;
        applyStimulus(1'b1, 4'h5);
        testsRun++;
        if (laneOperands[0] !== 16'h0000) begin testsFailed++; $display("[TB] FAIL vector_elem0_operand: got %h, expected 0000", laneOperands[0]); end
        @(negedge clk);
        testsRun++;
        if ({laneInValid, laneOperands[1]} !== {1'b1, 16'h1111}) begin testsFailed++; $display("[TB] FAIL vector_elem1_operand: got %h, expected 11111", {laneInValid, laneOperands[1]}); end
        waitValid(cyc);
        testsRun++;
        if (cyc + 1 !== 3) begin testsFailed++; $display("[TB] FAIL vector_latency: got %0d, expected 3", cyc + 1); end
        testsRun++;
        if (result !== 32'h4000_3C00) begin testsFailed++; $display("[TB] FAIL vector_result: got %h, expected 40003c00", result); end
        testsRun++;
        if (status !== 5'b00101) begin testsFailed++; $display("[TB] FAIL vector_status: got %b, expected 00101", status); end
        testsRun++;
        if ({extBit, tagOut} !== {1'b0, 4'h5}) begin testsFailed++; $display("[TB] FAIL vector_ext_tag: got %h, expected 05", {extBit, tagOut}); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            testsRun++;
            if ({outValid, inReady, result, status, tagOut} !== {1'b1, 1'b0, 32'h4000_3C00, 5'b00101, 4'h5}) begin
                testsFailed++;
                $display("[TB] FAIL backpressure_hold cycle %0d: got %h, expected %h", i, {outValid, inReady, result, status, tagOut}, {1'b1, 1'b0, 32'h4000_3C00, 5'b00101, 4'h5});
            end
        end
        completeOp();
        testsRun++;
        if ({outValid, inReady, busy} !== 3'b010) begin testsFailed++; $display("[TB] FAIL backpressure_release: got %b, expected 010", {outValid, inReady, busy}); end
    endtask

    task automatic test_stall();
        int cyc;
        laneAuto = 1'b1; laneReady = 1'b1;
        applyStimulus(1'b1, 4'h6);
        @(negedge clk);
        laneReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if ({laneInValid, laneOperands[1], laneOperands[0]} !== {1'b1, 16'h1111, 16'h0001}) begin
                testsFailed++;
                $display("[TB] FAIL stall_operands_stable step %0d: got %h, expected %h", i, {laneInValid, laneOperands[1], laneOperands[0]}, {1'b1, 16'h1111, 16'h0001});
            end
            if (i < 3) @(negedge clk);
        end
        laneReady = 1'b1;
        waitValid(cyc);
        testsRun++;
        if (cyc + 4 !== 6) begin testsFailed++; $display("[TB] FAIL stall_latency: got %0d, expected 6", cyc + 4); end
        testsRun++;
        if (result !== 32'h4000_3C00) begin testsFailed++; $display("[TB] FAIL stall_result: got %h, expected 40003c00", result); end
        completeOp();
    endtask

    task automatic test_flush();
        int cyc;
        laneAuto = 1'b0; laneManValid = 1'b0; laneReady = 1'b1;
        applyStimulus(1'b1, 4'h7);
        @(negedge clk);
        flush = 1'b1;
        #1;
        testsRun++;
        if (laneFlush !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_passthrough: got %b, expected 1", laneFlush); end
        @(negedge clk);
        flush = 1'b0;
        testsRun++;
        if ({busy, outValid, inReady} !== 3'b001) begin testsFailed++; $display("[TB] FAIL flush_to_idle: got %b, expected 001", {busy, outValid, inReady}); end
        laneManValid = 1'b1;
        laneManData  = 16'hDEAD;
        #1;
        testsRun++;
        if (laneOutReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_drain_ready: got %b, expected 1", laneOutReady); end
        @(negedge clk);
        laneManValid = 1'b0;
        testsRun++;
        if ({busy, outValid} !== 2'b00) begin testsFailed++; $display("[TB] FAIL flush_stale_ignored: got %b, expected 00", {busy, outValid}); end
        inValid = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        flush   = 1'b0;
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_discards_accept: got %b, expected 0", busy); end
        laneAuto = 1'b1;
        resp0Data = 16'h1234; resp0Status = 5'b0; resp0Ext = 1'b0;
        applyStimulus(1'b0, 4'h8);
        waitValid(cyc);
        testsRun++;
        if (cyc !== 2) begin testsFailed++; $display("[TB] FAIL flush_next_latency: got %0d, expected 2", cyc); end
        testsRun++;
        if ({result, status, tagOut} !== {32'h0000_1234, 5'b0, 4'h8}) begin testsFailed++; $display("[TB] FAIL flush_next_result: got %h, expected %h", {result, status, tagOut}, {32'h0000_1234, 5'b0, 4'h8}); end
        completeOp();
    endtask

    task automatic test_reset_mid_run();
        laneAuto = 1'b0; laneManValid = 1'b0; laneReady = 1'b1;
        applyStimulus(1'b1, 4'h9);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        testsRun++;
        if ({inReady, outValid, laneInValid, busy, result, status} !== {4'b1000, 32'h0, 5'b0}) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_run: got %h, expected %h", {inReady, outValid, laneInValid, busy, result, status}, {4'b1000, 32'h0, 5'b0});
        end
        @(negedge clk);
        rstN = 1'b1;
        laneAuto = 1'b1;
        repeat (4) @(negedge clk);
        testsRun++;
        if ({outValid, busy} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_mid_run_quiet: got %b, expected 00", {outValid, busy}); end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0;
        operands = '0; isBoxed = '0; rndMode = RNE; op = FMADD; opMod = 1'b0;
        vectorialOp = 1'b0; tag = '0; inValid = 1'b0; flush = 1'b0; outReady = 1'b0;
        laneAuto = 1'b1; laneReady = 1'b1; laneManValid = 1'b0; laneManData = '0;
        resp0Data = '0; resp1Data = '0; resp0Status = '0; resp1Status = '0;
        resp0Ext = 1'b0; resp1Ext = 1'b0;
        test_reset();
        test_scalar();
        test_vector();
        test_backpressure();
        test_stall();
        test_flush();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
